instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Fetch sequencer placed in front of the combinational, byte-addressed, little-endian instruction memory (32-bit words, 10 instructions / 40 bytes by default).
- Owns the fetch PC and drives it to the memory each cycle.
- Captures the returned word into a small prefetch FIFO and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO, and stops fetching at the end of the program image.

Parameters:
- MEM_BYTES, 40, size of instruction memory in bytes; fetch stops at or beyond this address.
- RESET_PC, 0, fetch PC loaded at reset; word-aligned.
- FIFO_DEPTH, 2, prefetch FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_pc  out  32  byte address to the instruction memory; equals the registered fetch_pc.
- imem_data  in  32  instruction word returned combinationally for imem_pc in the same cycle.
- redirect_valid  in  1  taken branch/jump from the execute stage.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored (treated as 0).
- if_valid  out  1  FIFO head holds a valid instruction.
- if_ready  in  1  decode accepts the head this cycle.
- if_instr  out  32  head instruction; 0 when if_valid=0.
- if_pc  out  32  head instruction's byte address; 0 when if_valid=0.
- halted  out  1  end of image reached and FIFO drained.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, state=RUN.
  - if_valid=0, if_instr=0, if_pc=0, halted=0.
  - Reset mid-stream discards all FIFO contents.
- States:
  - RUN: fetching.
  - HALT: no fetches; imem_pc holds its value.
- Definitions:
  - pop = if_valid & if_ready.
  - push = (state==RUN) & (count<FIFO_DEPTH | pop).
- On push:
  - Write {fetch_pc, imem_data} at wr_ptr; fetch_pc <= fetch_pc+4.
  - If fetch_pc+4 >= MEM_BYTES, next state = HALT.
- On pop: rd_ptr advances.
- Count update: count += push - pop. A push and a pop in the same cycle with a full FIFO is legal; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1), which has priority over push and pop in the same cycle:
  - FIFO is flushed (count=0, pointers=0); a pop in that cycle is still a valid handshake for the current head.
  - The imem word for that cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - State = RUN if the aligned target < MEM_BYTES, else HALT.
  - Redirect while in HALT restarts fetching.
- Outputs:
  - if_valid = (count!=0); head data is driven from the FIFO registers (no combinational path from imem_data to if_*).
  - halted = (state==HALT) & (count==0).
- Latency and throughput:
  - First instruction presented 1 cycle after the first post-reset edge.
  - Redirect-to-first-valid latency is 1 cycle.
  - Sustained throughput is 1 instruction/cycle with if_ready held at 1.
- Backpressure: if_ready=0 with a full FIFO stalls fetch_pc. Head data stays stable while if_valid=1 and if_ready=0.
- Arithmetic: fetch_pc is 32-bit and wraps mod 2^32. The halt compare is unsigned.

Decomposition:
- Shared package: XLEN=32, INSTR_BYTES=4, NOP encoding 32'h00000013, and a fetch_state enum {RUN, HALT}.
- One sub-module: fetch_fifo. It is a synchronous FIFO (data width 64: pc+instr) with push/pop/flush, count, full/empty. The controller keeps the PC, the FSM and the redirect logic.

Test Plan:
- Reset, then if_ready=1 constantly, memory at its default image:
  - if_valid rises 1 cycle after reset release.
  - Decode receives pc 0,4,...,36 with instr 0x00500093, 0x00766113, ..., 0x0041C533 on consecutive cycles.
  - halted=1 the cycle after pc 36 is accepted.
- if_ready=0 for 5 cycles after reset:
  - FIFO fills with pc 0,4; imem_pc holds 8; if_pc stays 0.
  - After release, pc 0,4,8 are delivered in order with no loss or duplication.
- Redirect at pc 12 to target 0x1E:
  - FIFO flushed; next delivered if_pc=0x1C with instr 0x401203B3, then 0x20.
- Redirect to 40 (≥ MEM_BYTES):
  - halted=1 the next cycle; if_valid stays 0.
  - A following redirect to 8 resumes delivery at pc 8 (instr 0x00A50193).
- Redirect in the same cycle as a full-FIFO pop and push:
  - Popped head counted once; pushed word dropped; count=0; next if_pc = target.
- rst asserted while the FIFO holds 2 entries:
  - Next cycle if_valid=0, imem_pc=RESET_PC; delivery restarts at pc 0.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// instr_fetch_ctrl_pkg: shared widths, NOP encoding, fetch FSM states and PC alignment helper
package instr_fetch_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  typedef enum logic {RUN, HALT} fetch_state_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: fetch bus (imem_pc/imem_data, redirect_valid/redirect_pc, if_valid/if_ready/if_instr/if_pc, halted); master=fetch controller, slave=memory/execute/decode side
interface instr_fetch_ctrl_if;
  import instr_fetch_ctrl_pkg::*;
  logic [XLEN-1:0] imem_pc, imem_data, redirect_pc, if_instr, if_pc;
  logic redirect_valid, if_valid, if_ready, halted;
  modport master(output imem_pc, if_valid, if_instr, if_pc, halted, input imem_data, redirect_valid, redirect_pc, if_ready);
  modport slave(input imem_pc, if_valid, if_instr, if_pc, halted, output imem_data, redirect_valid, redirect_pc, if_ready);
endinterface

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// instr_fetch_ctrl_fetch_fifo: sync FIFO (clk, rst, i_push/i_pop/i_flush, i_wdata -> o_rdata head, o_count, o_full, o_empty); flush wins over push/pop
module instr_fetch_ctrl_fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [W-1:0]           i_wdata,
  output logic [W-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_count;
  always_ff @(posedge clk)
    if (i_push && !i_flush) r_mem[r_wr] <= i_wdata;
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
    end else begin
      r_wr <= i_push ? r_wr + 1'b1 : r_wr;
      r_rd <= i_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end
  assign o_rdata = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch PC/FSM/redirect in front of a combinational imem, prefetch FIFO to decode (clk, rst, bus: imem_pc/imem_data, redirect_*, if_*, halted)
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int          MEM_BYTES  = 40,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_ctrl_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt, w_pc_inc, w_target;
  logic w_push, w_pop, w_full, w_empty;
  logic [2*XLEN-1:0] w_head;
  logic [CW-1:0] w_count;
  assign w_pc_inc = r_pc + 32'(INSTR_BYTES);
  assign w_target = word_align(bus.redirect_pc);
  assign w_pop = bus.if_valid & bus.if_ready;
  always_comb begin
    w_push = (r_state == RUN) & (!w_full | w_pop) & !bus.redirect_valid;
    w_pc_nxt = bus.redirect_valid ? w_target : w_push ? w_pc_inc : r_pc;
    w_state_nxt = bus.redirect_valid ? (w_target < 32'(MEM_BYTES) ? RUN : HALT)
                : (w_push && w_pc_inc >= 32'(MEM_BYTES)) ? HALT : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc <= w_pc_nxt;
    end
  end
  instr_fetch_ctrl_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(2*XLEN)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_flush(bus.redirect_valid),
    .i_wdata({r_pc, bus.imem_data}),
    .o_rdata(w_head),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  assign bus.imem_pc = r_pc;
  assign bus.if_valid = w_count != '0;
  assign bus.if_pc = bus.if_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign bus.if_instr = bus.if_valid ? w_head[XLEN-1:0] : '0;
  assign bus.halted = (r_state == HALT) & w_empty;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed stimulus with a queue scoreboard checked by a decode-side monitor
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int n_chk = 0;
  int n_pass = 0;
  logic [63:0] q[$];
  logic [63:0] mon_e;
  logic [31:0] img [10] = '{32'h00500093, 32'h00766113, 32'h00A50193, 32'h00208233, 32'h402182B3,
                            32'h00F2F313, 32'h0062E3B3, 32'h401203B3, 32'h00139413, 32'h0041C533};
  instr_fetch_ctrl_if bus();
  instr_fetch_ctrl dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always_comb bus.imem_data = bus.imem_pc < 32'd40 ? img[bus.imem_pc[5:2]] : NOP;
  always @(negedge clk) begin
    if (!rst && bus.if_valid && bus.if_ready) begin
      n_chk++;
      if (q.size() == 0) $display("FAIL deliver: unexpected pc %h instr %h, none required", bus.if_pc, bus.if_instr);
      else begin
        mon_e = q.pop_front();
        if ({bus.if_pc, bus.if_instr} === mon_e) n_pass++;
        else $display("FAIL deliver: got pc %h instr %h, required pc %h instr %h", bus.if_pc, bus.if_instr, mon_e[63:32], mon_e[31:0]);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr);
    q.push_back({pc, instr});
  endtask
  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d deliveries outstanding, required 0", q.size());
      q.delete();
    end
    bus.if_ready = 0;
  endtask
  initial begin
    int n;
    bus.if_ready = 1;
    do_reset();
    chk("rst_valid", 32'(bus.if_valid), 0);
    chk("rst_pc", bus.if_pc, 0);
    chk("rst_instr", bus.if_instr, 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_imem_pc", bus.imem_pc, 0);
    for (int i = 0; i < 10; i++) exp_push(32'(i * 4), img[i]);
    tick();
    chk("first_valid", 32'(bus.if_valid), 1);
    n = 1;
    while (q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("throughput_cycles", 32'(n), 11);
    chk("end_halted", 32'(bus.halted), 1);
    chk("end_valid", 32'(bus.if_valid), 0);
    q.delete();
    bus.if_ready = 0;
    do_reset();
    repeat (5) tick();
    chk("bp_imem_pc", bus.imem_pc, 32'd8);
    chk("bp_if_pc", bus.if_pc, 0);
    chk("bp_if_instr", bus.if_instr, 32'h00500093);
    chk("bp_valid", 32'(bus.if_valid), 1);
    exp_push(0, 32'h00500093);
    exp_push(4, 32'h00766113);
    exp_push(8, 32'h00A50193);
    bus.if_ready = 1;
    drain();
    bus.if_ready = 1;
    do_reset();
    exp_push(0, 32'h00500093);
    exp_push(4, 32'h00766113);
    exp_push(8, 32'h00A50193);
    drain();
    chk("redir_head", bus.if_pc, 32'd12);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h1E;
    tick();
    bus.redirect_valid = 0;
    chk("redir_flush", 32'(bus.if_valid), 0);
    chk("redir_imem_pc", bus.imem_pc, 32'h1C);
    exp_push(32'h1C, 32'h401203B3);
    exp_push(32'h20, 32'h00139413);
    bus.if_ready = 1;
    tick();
    chk("redir_latency", 32'(bus.if_valid), 1);
    drain();
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'd40;
    tick();
    bus.redirect_valid = 0;
    chk("oob_halted", 32'(bus.halted), 1);
    chk("oob_valid", 32'(bus.if_valid), 0);
    tick();
    tick();
    chk("oob_valid_hold", 32'(bus.if_valid), 0);
    chk("oob_imem_pc", bus.imem_pc, 32'd40);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'd8;
    bus.if_ready = 1;
    exp_push(8, 32'h00A50193);
    exp_push(12, 32'h00208233);
    tick();
    bus.redirect_valid = 0;
    chk("resume_halted", 32'(bus.halted), 0);
    drain();
    do_reset();
    repeat (3) tick();
    chk("full_valid", 32'(bus.if_valid), 1);
    bus.if_ready = 1;
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h10;
    exp_push(0, 32'h00500093);
    tick();
    bus.redirect_valid = 0;
    bus.if_ready = 0;
    chk("rp_popped", 32'(q.size()), 0);
    chk("rp_flush", 32'(bus.if_valid), 0);
    chk("rp_imem_pc", bus.imem_pc, 32'h10);
    exp_push(32'h10, 32'h402182B3);
    exp_push(32'h14, 32'h00F2F313);
    bus.if_ready = 1;
    drain();
    do_reset();
    repeat (3) tick();
    chk("pre_rst_valid", 32'(bus.if_valid), 1);
    rst = 1;
    tick();
    chk("mid_rst_valid", 32'(bus.if_valid), 0);
    chk("mid_rst_imem_pc", bus.imem_pc, 0);
    chk("mid_rst_halted", 32'(bus.halted), 0);
    rst = 0;
    exp_push(0, 32'h00500093);
    exp_push(4, 32'h00766113);
    bus.if_ready = 1;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
